// File: rtl/uart_cmd_ctrl.sv
// UART byte-stream command decoder: turns a command byte plus optional data
// bytes into register-bank write strobes or read requests.
module uart_cmd_ctrl #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_BYTES  = 1,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_int,
    input  logic                    rd_ack,
    output logic [ADDR_W-1:0]       reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_wrdata,
    output logic                    wr_en,
    output logic                    rd_req,
    output logic                    busy,
    output logic                    err_addr,
    output logic                    err_timeout,
    output logic                    err_drop
);

    localparam int unsigned DATA_W = 8 * DATA_BYTES;
    localparam int unsigned BCNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYC != 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(DATA_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYC);
    localparam bit                TMO_EN    = (TIMEOUT_CYC != 0);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WDATA   = 2'd1;
    localparam logic [1:0] WCOMMIT = 2'd2;
    localparam logic [1:0] RDREQ   = 2'd3;

    logic [1:0]        state, state_nxt;
    logic              rx_int_d;
    logic [BCNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt, tmo_inc;
    logic              tmo_hit;
    logic              ev;
    logic [6:0]        addr_hi;
    logic              addr_bad;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wrdata_nxt;
    logic              err_addr_nxt, err_timeout_nxt, err_drop_nxt;

    assign ev       = rx_int_d & ~rx_int;
    assign addr_hi  = rx_data[6:0] >> ADDR_W;
    assign addr_bad = |addr_hi;

    // Counter saturates at TIMEOUT_CYC; the timeout fires on the edge that would reach it.
    assign tmo_inc = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
    assign tmo_hit = TMO_EN && (tmo_inc == TMO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rx_int_d <= 1'b0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            rx_int_d <= rx_int;
            byte_cnt <= byte_cnt_nxt;
            tmo_cnt  <= tmo_nxt;
        end
    end

    // Next state, datapath and error decode; byte events and acks beat a coincident timeout.
    always_comb begin
        state_nxt       = state;
        byte_cnt_nxt    = byte_cnt;
        tmo_nxt         = '0;
        addr_nxt        = reg_addr;
        wrdata_nxt      = reg_wrdata;
        err_addr_nxt    = 1'b0;
        err_timeout_nxt = 1'b0;
        err_drop_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (ev) begin
                    if (addr_bad) begin
                        err_addr_nxt = 1'b1;
                    end else begin
                        addr_nxt     = rx_data[ADDR_W-1:0];
                        byte_cnt_nxt = '0;
                        state_nxt    = rx_data[7] ? WDATA : RDREQ;
                    end
                end
            end
            WDATA: begin
                if (ev) begin
                    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                        if (byte_cnt == BCNT_W'(i)) begin
                            wrdata_nxt[8*i +: 8] = rx_data;
                        end
                    end
                    byte_cnt_nxt = byte_cnt + 1'b1;
                    if (byte_cnt == LAST_BYTE) begin
                        state_nxt = WCOMMIT;
                    end
                end else if (tmo_hit) begin
                    state_nxt       = IDLE;
                    err_timeout_nxt = 1'b1;
                end else begin
                    tmo_nxt = tmo_inc;
                end
            end
            WCOMMIT: begin
                state_nxt    = IDLE;
                err_drop_nxt = ev;
            end
            RDREQ: begin
                err_drop_nxt = ev;
                if (rd_ack) begin
                    state_nxt = IDLE;
                end else if (ev) begin
                    tmo_nxt = tmo_inc;
                end else if (tmo_hit) begin
                    state_nxt       = IDLE;
                    err_timeout_nxt = 1'b1;
                end else begin
                    tmo_nxt = tmo_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, timed to track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr    <= '0;
            reg_wrdata  <= '0;
            wr_en       <= 1'b0;
            rd_req      <= 1'b0;
            busy        <= 1'b0;
            err_addr    <= 1'b0;
            err_timeout <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            reg_addr    <= addr_nxt;
            reg_wrdata  <= wrdata_nxt;
            wr_en       <= (state_nxt == WCOMMIT);
            rd_req      <= (state_nxt == RDREQ);
            busy        <= (state_nxt != IDLE);
            err_addr    <= err_addr_nxt;
            err_timeout <= err_timeout_nxt;
            err_drop    <= err_drop_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural command-level model.
module tb_uart_cmd_ctrl;

    localparam int ADDR_W      = 5;
    localparam int DATA_BYTES  = 2;
    localparam int TIMEOUT_CYC = 100;
    localparam int DATA_W      = 8 * DATA_BYTES;
    localparam int VEC_W       = ADDR_W + DATA_W + 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_int = 1'b0;
    logic              rd_ack = 1'b0;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wrdata;
    logic              wr_en, rd_req, busy, err_addr, err_timeout, err_drop;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_BYTES  (DATA_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_int      (rx_int),
        .rd_ack      (rd_ack),
        .reg_addr    (reg_addr),
        .reg_wrdata  (reg_wrdata),
        .wr_en       (wr_en),
        .rd_req      (rd_req),
        .busy        (busy),
        .err_addr    (err_addr),
        .err_timeout (err_timeout),
        .err_drop    (err_drop)
    );

    // Model: phase 0 idle, 1 collecting data, 2 committing, 3 reading
    int                m_phase = 0;
    bit                m_prev  = 1'b0;
    int                m_got   = 0;
    int                m_quiet = 0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [DATA_W-1:0] m_word  = '0;
    bit m_wr = 0, m_rd = 0, m_busy = 0, m_ea = 0, m_et = 0, m_ed = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [VEC_W-1:0] dut_v, mdl_v;
    assign dut_v = {reg_addr, reg_wrdata, wr_en, rd_req, busy, err_addr, err_timeout, err_drop};
    assign mdl_v = {m_addr, m_word, m_wr, m_rd, m_busy, m_ea, m_et, m_ed};

    task automatic model_reset();
        m_phase = 0; m_prev = 0; m_got = 0; m_quiet = 0;
        m_addr = '0; m_word = '0;
        m_wr = 0; m_rd = 0; m_busy = 0; m_ea = 0; m_et = 0; m_ed = 0;
    endtask

    task automatic model_step();
        bit fell;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fell   = m_prev && !rx_int;
        m_prev = rx_int;
        m_ea = 0; m_et = 0; m_ed = 0;
        case (m_phase)
            0: if (fell) begin
                if (int'(rx_data[6:0]) >= (1 << ADDR_W)) m_ea = 1;
                else begin
                    m_addr  = rx_data[ADDR_W-1:0];
                    m_got   = 0;
                    m_quiet = 0;
                    m_phase = rx_data[7] ? 1 : 3;
                end
            end
            2: begin
                m_ed    = fell;
                m_phase = 0;
            end
            default: begin
                if (m_phase == 1 && fell) begin
                    m_word[8*m_got +: 8] = rx_data;
                    m_got++;
                    m_quiet = 0;
                    if (m_got == DATA_BYTES) m_phase = 2;
                end else if (m_phase == 3 && rd_ack) begin
                    m_ed    = fell;
                    m_phase = 0;
                end else if (m_phase == 3 && fell) begin
                    m_ed = 1;
                    if (m_quiet < TIMEOUT_CYC) m_quiet++;
                end else if (TIMEOUT_CYC != 0 && m_quiet + 1 >= TIMEOUT_CYC) begin
                    m_et    = 1;
                    m_phase = 0;
                end else begin
                    m_quiet++;
                end
            end
        endcase
        m_wr   = (m_phase == 2);
        m_rd   = (m_phase == 3);
        m_busy = (m_phase != 0);
    endtask

    // One clock: inputs change at negedge, model advances at posedge, caller samples at negedge.
    task automatic tick(input logic ri, input logic [7:0] d, input logic ack);
        rx_int = ri; rx_data = d; rd_ack = ack;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick(1'b1, b, 1'b0);
        tick(1'b0, b, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_v); end
        rst_n = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_v !== mdl_v) begin n_fail++; $display("FAIL reset_release: dut %h model %h", dut_v, mdl_v); end
    endtask

    task automatic test_write();
        int pulses = 0;
        send_byte(8'h83);
        send_byte(8'h34);
        n_cmp++;
        if (dut_v !== mdl_v) begin n_fail++; $display("FAIL write_mid: dut %h model %h", dut_v, mdl_v); end
        send_byte(8'h12);
        n_cmp++;
        if (wr_en !== 1'b1 || reg_wrdata !== 16'h1234 || reg_addr !== 5'h03) begin
            n_fail++; $display("FAIL write_commit: wr_en %b data %h addr %h want 1 1234 03", wr_en, reg_wrdata, reg_addr);
        end
        pulses += int'(wr_en);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            pulses += int'(wr_en);
            n_cmp++;
            if (dut_v !== mdl_v) begin n_fail++; $display("FAIL write_tail%0d: dut %h model %h", i, dut_v, mdl_v); end
        end
        n_cmp++;
        if (pulses != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL write_pulse: pulses %0d busy %b want 1 0", pulses, busy);
        end
    endtask

    task automatic test_read();
        int highs = 0;
        send_byte(8'h05);
        highs += int'(rd_req);
        n_cmp++;
        if (reg_addr !== 5'h05 || busy !== 1'b1) begin
            n_fail++; $display("FAIL read_start: addr %h busy %b want 05 1", reg_addr, busy);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            highs += int'(rd_req);
            n_cmp++;
            if (dut_v !== mdl_v) begin n_fail++; $display("FAIL read_wait%0d: dut %h model %h", i, dut_v, mdl_v); end
        end
        tick(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (highs != 11 || rd_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL read_ack: high %0d rd_req %b busy %b want 11 0 0", highs, rd_req, busy);
        end
    endtask

    task automatic test_bad_addr();
        logic [ADDR_W-1:0] prev_addr;
        prev_addr = reg_addr;
        send_byte(8'hA0);
        n_cmp++;
        if (err_addr !== 1'b1 || busy !== 1'b0 || reg_addr !== prev_addr) begin
            n_fail++; $display("FAIL bad_addr: err %b busy %b addr %h want 1 0 %h", err_addr, busy, reg_addr, prev_addr);
        end
        tick(1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (dut_v !== mdl_v) begin n_fail++; $display("FAIL bad_addr_after: dut %h model %h", dut_v, mdl_v); end
    endtask

    task automatic test_timeout();
        send_byte(8'h81);
        send_byte(8'h5A);
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (dut_v !== mdl_v) begin n_fail++; $display("FAIL timeout_cyc%0d: dut %h model %h", k, dut_v, mdl_v); end
        end
        n_cmp++;
        if (err_timeout !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || reg_wrdata !== 16'h125A) begin
            n_fail++; $display("FAIL timeout_fire: et %b wr %b busy %b data %h want 1 0 0 125a",
                               err_timeout, wr_en, busy, reg_wrdata);
        end
        tick(1'b0, 8'h00, 1'b0);
        // Second attempt: last byte lands exactly on the timeout cycle
        send_byte(8'h81);
        send_byte(8'h11);
        for (int k = 1; k <= TIMEOUT_CYC - 2; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (dut_v !== mdl_v) begin n_fail++; $display("FAIL edge_cyc%0d: dut %h model %h", k, dut_v, mdl_v); end
        end
        send_byte(8'h22);
        n_cmp++;
        if (err_timeout !== 1'b0 || wr_en !== 1'b1 || reg_wrdata !== 16'h2211) begin
            n_fail++; $display("FAIL timeout_edge: et %b wr %b data %h want 0 1 2211", err_timeout, wr_en, reg_wrdata);
        end
        tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_drop();
        send_byte(8'h02);
        send_byte(8'h77);
        n_cmp++;
        if (err_drop !== 1'b1 || rd_req !== 1'b1 || reg_addr !== 5'h02) begin
            n_fail++; $display("FAIL drop: err %b rd_req %b addr %h want 1 1 02", err_drop, rd_req, reg_addr);
        end
        tick(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (dut_v !== mdl_v) begin n_fail++; $display("FAIL drop_ack: dut %h model %h", dut_v, mdl_v); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h81);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_v !== '0) begin n_fail++; $display("FAIL reset_mid: got %h want 0", dut_v); end
        model_reset();
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        send_byte(8'h84);
        send_byte(8'hCD);
        send_byte(8'hAB);
        n_cmp++;
        if (wr_en !== 1'b1 || reg_wrdata !== 16'hABCD || reg_addr !== 5'h04 || dut_v !== mdl_v) begin
            n_fail++; $display("FAIL reset_resume: wr %b data %h addr %h want 1 abcd 04", wr_en, reg_wrdata, reg_addr);
        end
        tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        int         quiet = 0;
        logic       ri = 1'b0;
        logic       ack;
        logic [7:0] d;
        for (int n = 0; n < 5000; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 7) != 0) d[6:5] = 2'b00;
            ack = 1'b0;
            if (quiet > 0) begin
                ri = 1'b0;
                quiet--;
            end else if ($urandom_range(0, 199) == 0) begin
                quiet = int'($urandom_range(TIMEOUT_CYC - 5, TIMEOUT_CYC + 5));
            end else begin
                if ($urandom_range(0, 1) == 0) ri = ~ri;
                ack = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            tick(ri, d, ack);
            rst_n = 1'b1;
            n_cmp++;
            if (dut_v !== mdl_v) begin n_fail++; $display("FAIL random_%0d: dut %h model %h", n, dut_v, mdl_v); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
